id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_reset, input, 1; reset is asynchronous and active-high.
REQ-003 SHALL have port i_halt, input, 1, debug-unit freeze; holds all state.
REQ-004 SHALL have port i_flush, input, 1, branch/jump taken; squash the ID instruction.
REQ-005 SHALL have port i_ctrl, input, 17, decoder bundle {ALUBMux, LaMux, RegDst[1:0], ALUOp[5:0], MemWrite, MemRead, ByteSig[1:0], RegWrite, MemToReg[1:0]}, MSB first.
REQ-006 SHALL have ports i_pc4, i_rs_data, i_rt_data, i_imm, input, 32 each, PC+4, register-file reads, sign-extended immediate.
REQ-007 SHALL have ports i_rs, i_rt, i_rd, i_shamt, input, 5 each, instruction fields.
REQ-008 SHALL have ports o_ctrl (17), o_pc4, o_rs_data, o_rt_data, o_imm (32), o_rs, o_rt, o_rd, o_shamt (5), output, registered copies for EX.
REQ-009 SHALL have port o_valid, output, 1; EX slot holds a real instruction.
REQ-010 SHALL have port o_stall, output, 1, combinational load-use stall to PC and IF/ID.
REQ-011 SHALL have port o_bubble_cnt, output, 16, saturating count of inserted bubbles.

Function
REQ-012 SHALL compute o_stall = o_valid & o_ctrl.MemRead & (o_rt != 0) & (o_rt == i_rs | o_rt == i_rt) & ~i_halt.
REQ-013 SHALL apply per-edge priority: reset > i_halt > i_flush > o_stall > load.
REQ-014 i_halt=1 SHALL hold every register, o_valid and o_bubble_cnt unchanged.
REQ-015 i_flush=1 (no halt) SHALL load a bubble: o_ctrl=0, all data/field outputs=0, o_valid=0.
REQ-016 o_stall=1 (no halt, no flush) SHALL load a bubble as in REQ-015; the ID inputs are re-presented next cycle by the held upstream stage.
REQ-017 Otherwise SHALL load all inputs with one-cycle latency and set o_valid=1.
REQ-018 Each edge loading a bubble per REQ-015/016 SHALL increment o_bubble_cnt by 1, saturating at 16'hFFFF; no wrap.
REQ-019 Simultaneous i_flush and o_stall SHALL count exactly one bubble.
REQ-020 A load-use stall SHALL last exactly one cycle: after the bubble o_valid=0, so o_stall deasserts.
REQ-021 o_rt=0 SHALL never cause a stall, even when MemRead=1.
REQ-022 Data fields SHALL pass unmodified; no sign or width conversion in this block.

Reset
REQ-023 i_reset=1 SHALL immediately clear all outputs to 0, including o_valid, o_bubble_cnt and o_stall, regardless of clock.
REQ-024 Reset deasserted mid-stream SHALL resume normal loading on the first rising edge after deassertion, with no residual bubble.

Verification
REQ-025 Plain load: i_ctrl=ADDI bundle (ALUBMux=1, RegWrite=1, MemToReg=2'b10, ALUOp=6'b000010), i_imm=32'h0000_0005 -> one edge later o_ctrl/o_imm equal inputs, o_valid=1, o_stall=0.
REQ-026 Load-use: LW with rt=5 in EX, ID i_rs=5 -> o_stall=1 same cycle; next edge o_ctrl=0, o_valid=0, o_bubble_cnt=1; following edge the held instruction loads, o_stall=0.
REQ-027 Zero-register: LW with rt=0 in EX, ID i_rt=0 -> o_stall=0, instruction loads normally.
REQ-028 Flush plus stall: i_flush=1 while o_stall=1 -> one bubble, o_bubble_cnt increments by exactly 1.
REQ-029 Halt: i_halt=1 for 3 cycles with changing inputs -> all outputs constant and o_stall=0; release -> normal load resumes.
REQ-030 Async reset/saturation: preload o_bubble_cnt=16'hFFFE, force two bubbles -> count 16'hFFFF and holds; pulse i_reset between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/halt handling
// and a saturating count of inserted bubbles.

module id_ex_bubble_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);
    // Sticks at all-ones instead of wrapping so long runs stay monotonic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (en && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module id_ex_stage #(
    parameter int CTRL_W = 17,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_halt,
    input  logic              i_flush,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_pc4,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_rt,
    input  logic [REG_W-1:0]  i_rd,
    input  logic [REG_W-1:0]  i_shamt,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_pc4,
    output logic [DATA_W-1:0] o_rs_data,
    output logic [DATA_W-1:0] o_rt_data,
    output logic [DATA_W-1:0] o_imm,
    output logic [REG_W-1:0]  o_rs,
    output logic [REG_W-1:0]  o_rt,
    output logic [REG_W-1:0]  o_rd,
    output logic [REG_W-1:0]  o_shamt,
    output logic              o_valid,
    output logic              o_stall,
    output logic [CNT_W-1:0]  o_bubble_cnt
);
    // Control bundle layout, MSB first:
    // {ALUBMux, LaMux, RegDst[1:0], ALUOp[5:0], MemWrite, MemRead, ByteSig[1:0], RegWrite, MemToReg[1:0]}
    localparam int MEMREAD_BIT = 5;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  shamt;
    } idex_t;

    idex_t id_d, ex_q;
    logic  valid_q;
    logic  ex_load;
    logic  rt_hit;
    logic  bubble;

    assign id_d = '{ctrl: i_ctrl, pc4: i_pc4, rs_data: i_rs_data, rt_data: i_rt_data,
                    imm: i_imm, rs: i_rs, rt: i_rt, rd: i_rd, shamt: i_shamt};

    // Load in EX whose destination is read by ID; $zero is never a real dependency.
    assign ex_load = valid_q & ex_q.ctrl[MEMREAD_BIT];
    assign rt_hit  = (ex_q.rt != '0) & ((ex_q.rt == i_rs) | (ex_q.rt == i_rt));
    assign o_stall = ex_load & rt_hit & ~i_halt;

    // Flush and stall share one bubble, so they are counted once together.
    assign bubble  = ~i_halt & (i_flush | o_stall);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else if (!i_halt) begin
            if (bubble) begin
                ex_q    <= '0;
                valid_q <= 1'b0;
            end else begin
                ex_q    <= id_d;
                valid_q <= 1'b1;
            end
        end
    end

    id_ex_bubble_cnt #(.W(CNT_W)) u_bubble_cnt (
        .clk (i_clk),
        .rst (i_reset),
        .en  (bubble),
        .cnt (o_bubble_cnt)
    );

    assign o_ctrl    = ex_q.ctrl;
    assign o_pc4     = ex_q.pc4;
    assign o_rs_data = ex_q.rs_data;
    assign o_rt_data = ex_q.rt_data;
    assign o_imm     = ex_q.imm;
    assign o_rs      = ex_q.rs;
    assign o_rt      = ex_q.rt;
    assign o_rd      = ex_q.rd;
    assign o_shamt   = ex_q.shamt;
    assign o_valid   = valid_q;
endmodule
